// File: rtl/hsync_provider.sv
// Horizontal VGA timing for the 640x400 mode: pixel-clock divider, line counter,
// and registered HSYNC / new_row / visible / X outputs derived from the next count.
module hsync_provider #(
  parameter int CLK_DIV              = 2,
  parameter int HorizontalFrontPorch = 16,
  parameter int HSYNCPulse           = 96,
  parameter int HorizontalBackPorch  = 48,
  parameter int VisibleColumns       = 640,
  parameter int HSYNC_ACTIVE         = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pixel_tick,
  output logic       HSYNC,
  output logic       new_row,
  output logic       h_visible,
  output logic [9:0] X
);

  localparam int TOTAL = HorizontalFrontPorch + HSYNCPulse + HorizontalBackPorch + VisibleColumns;
  localparam int HW    = $clog2(TOTAL);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(TOTAL - 1);
  localparam logic [HW-1:0] SYNC_START = HW'(HorizontalFrontPorch);
  localparam logic [HW-1:0] SYNC_END   = HW'(HorizontalFrontPorch + HSYNCPulse);
  localparam logic [HW-1:0] VIS_START  = HW'(HorizontalFrontPorch + HSYNCPulse + HorizontalBackPorch);
  localparam logic          SYNC_ON    = (HSYNC_ACTIVE != 0);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] h_counter_q, h_counter_d;
  logic [HW-1:0] h_next;
  logic          hsync_q, hsync_d;
  logic          new_row_q, new_row_d;
  logic          h_visible_q, h_visible_d;
  logic [9:0]    x_q, x_d;
  logic          tick;

  always_comb begin
    tick        = enable && (div_cnt_q == DIV_LAST);
    div_cnt_d   = div_cnt_q;
    h_counter_d = h_counter_q;
    hsync_d     = hsync_q;
    new_row_d   = new_row_q;
    h_visible_d = h_visible_q;
    x_d         = x_q;
    h_next      = (h_counter_q == H_LAST) ? '0 : h_counter_q + 1'b1;

    if (enable) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    // Outputs are decoded from the count being loaded, so they line up with it exactly.
    if (tick) begin
      h_counter_d = h_next;
      hsync_d     = (h_next >= SYNC_START && h_next < SYNC_END) ? SYNC_ON : ~SYNC_ON;
      new_row_d   = (h_next == '0);
      h_visible_d = (h_next >= VIS_START);
      x_d         = (h_next >= VIS_START) ? 10'(h_next - VIS_START) : 10'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      h_counter_q <= '0;
      hsync_q     <= ~SYNC_ON;
      new_row_q   <= 1'b0;
      h_visible_q <= 1'b0;
      x_q         <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      h_counter_q <= h_counter_d;
      hsync_q     <= hsync_d;
      new_row_q   <= new_row_d;
      h_visible_q <= h_visible_d;
      x_q         <= x_d;
    end
  end

  // new_row clocks the vertical generator, so it comes straight from a flop.
  assign pixel_tick = tick && !reset;
  assign HSYNC      = hsync_q;
  assign new_row    = new_row_q;
  assign h_visible  = h_visible_q;
  assign X          = x_q;

endmodule

// File: tb/tb_hsync_provider.sv
// Bench for hsync_provider: table vectors from reset, hand sequences for
// free-run / freeze / async reset, randomized enable against a line-position model.
module tb_hsync_provider;

  localparam int CLK_DIV = 2;
  localparam int LINE    = 800;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       pixel_tick, HSYNC, new_row, h_visible;
  logic [9:0] X;
  logic       pixel_tick2, hsync2, new_row2, h_visible2;
  logic [9:0] x2;

  int   n_tests = 0;
  int   n_fail = 0;
  int   m_en = 0;
  int   clk_cnt = 0;
  int   rise_cnt = 0;
  int   last_rise = 0;
  logic prev_nr = 1'b0;

  hsync_provider dut (
    .clk(clk), .reset(reset), .enable(enable), .pixel_tick(pixel_tick),
    .HSYNC(HSYNC), .new_row(new_row), .h_visible(h_visible), .X(X)
  );

  hsync_provider #(.CLK_DIV(1), .HSYNC_ACTIVE(0)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .pixel_tick(pixel_tick2),
    .HSYNC(hsync2), .new_row(new_row2), .h_visible(h_visible2), .X(x2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int   cyc;
    logic pt;
    logic hs;
    logic nr;
    logic hv;
    int   x;
  } vec_t;

  function automatic logic [13:0] outs();
    return {pixel_tick, HSYNC, new_row, h_visible, X};
  endfunction

  // Reference: position on the line follows purely from enabled clocks since reset.
  function automatic logic [13:0] model();
    int         ticks = m_en / CLK_DIV;
    int         pos = ticks % LINE;
    logic       pt = enable && !reset && ((m_en % CLK_DIV) == CLK_DIV - 1);
    logic       hs = (pos >= 16) && (pos < 112);
    logic       nr = (ticks > 0) && (pos == 0);
    logic       hv = (pos >= 160);
    logic [9:0] x = hv ? 10'(pos - 160) : 10'd0;
    return {pt, hs, nr, hv, x};
  endfunction

  task automatic cmp(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got pt=%b hs=%b nr=%b vis=%b X=%0d, want pt=%b hs=%b nr=%b vis=%b X=%0d",
               name, $time, act[13], act[12], act[11], act[10], act[9:0],
               exp[13], exp[12], exp[11], exp[10], exp[9:0]);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic chk();
    cmp("model", outs(), model());
  endtask

  task automatic step(input logic en);
    @(posedge clk);
    clk_cnt++;
    if (enable && !reset) m_en++;
    @(negedge clk);
    enable = en;
    #1;
    if (new_row && !prev_nr) begin
      rise_cnt++;
      last_rise = clk_cnt;
    end
    prev_nr = new_row;
  endtask

  initial begin
    vec_t       vecs[14];
    logic [13:0] snap;
    int         g, base, seen, prev_rise, hs_cnt, r0, rc, rel;
    int         len, low, pz, phase;
    logic       p2;

    vecs[0]  = '{0,    1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1,    1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{2,    1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{31,   1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{32,   1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[5]  = '{223,  1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[6]  = '{224,  1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{318,  1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[8]  = '{320,  1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[9]  = '{322,  1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{1599, 1'b1, 1'b0, 1'b0, 1'b1, 639};
    vecs[11] = '{1600, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[12] = '{1601, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[13] = '{1602, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    repeat (2) @(negedge clk);
    #1;
    cmp("reset_state", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 10'd0});

    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    m_en   = 0;
    #1;

    for (int i = 0; i < 14; i++) begin
      while (m_en < vecs[i].cyc) step(1'b1);
      cmp($sformatf("vec%0d_cyc%0d", i, vecs[i].cyc), outs(),
          {vecs[i].pt, vecs[i].hs, vecs[i].nr, vecs[i].hv, 10'(vecs[i].x)});
    end

    // Free run: line period and HSYNC width.
    base = rise_cnt; seen = rise_cnt; prev_rise = last_rise; hs_cnt = 0; g = 0;
    while (rise_cnt < base + 3 && g < 6000) begin
      step(1'b1);
      chk();
      g++;
      if (HSYNC) hs_cnt++;
      if (rise_cnt != seen) begin
        cmp_int("line_len", last_rise - prev_rise, 1600);
        cmp_int("hsync_clks", hs_cnt, 192);
        prev_rise = last_rise;
        hs_cnt = 0;
        seen = rise_cnt;
      end
    end
    if (g >= 6000) timeout("free_run");

    // Freeze for 37 clks at X=300.
    g = 0;
    while (X != 10'd300 && g < 2000) begin step(1'b1); chk(); g++; end
    if (g >= 2000) timeout("reach_x300");
    enable = 1'b0;
    #1;
    cmp_int("freeze_ptick", int'(pixel_tick), 0);
    snap = outs();
    r0 = last_rise;
    rc = rise_cnt;
    for (int k = 0; k < 37; k++) begin
      step(1'b0);
      cmp("frozen", outs(), snap);
    end
    enable = 1'b1;
    #1;
    g = 0;
    while (X == 10'd300 && g < 10) begin step(1'b1); chk(); g++; end
    cmp_int("resume_x", int'(X), 301);
    g = 0;
    while (rise_cnt == rc && g < 4000) begin step(1'b1); chk(); g++; end
    if (g >= 4000) timeout("frozen_line");
    else cmp_int("frozen_line_len", last_rise - r0, 1637);

    // Asynchronous reset between edges at X=500.
    g = 0;
    while (X != 10'd500 && g < 4000) begin step(1'b1); chk(); g++; end
    if (g >= 4000) timeout("reach_x500");
    reset = 1'b1;
    #1;
    cmp("async_reset", outs(), 14'd0);
    m_en = 0;
    @(posedge clk);
    @(negedge clk);
    cmp("reset_hold", outs(), 14'd0);
    reset = 1'b0;
    prev_nr = 1'b0;
    rc = rise_cnt;
    rel = clk_cnt;
    #1;
    g = 0;
    while (rise_cnt == rc && g < 4000) begin step(1'b1); chk(); g++; end
    if (g >= 4000) timeout("post_reset_rise");
    else cmp_int("post_reset_rise", last_rise - rel, 1600);

    // Randomized enable with occasional mid-cycle resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1;
        cmp("rand_reset", outs(), 14'd0);
        m_en = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        prev_nr = 1'b0;
        #1;
        chk();
      end else begin
        step($urandom_range(0, 3) != 0);
        chk();
      end
    end

    // Active-low, undivided instance.
    @(negedge clk);
    reset = 1'b1;
    #1;
    cmp_int("dut2_reset_hsync", int'(hsync2), 1);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    m_en   = 0;
    p2 = 1'b0; g = 0; len = 0; low = 0; pz = 0; phase = 0;
    while (phase < 2 && g < 4000) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      g++;
      if (phase == 1) begin
        len++;
        if (!hsync2) low++;
        if (!pixel_tick2) pz++;
      end
      if (new_row2 && !p2) phase++;
      p2 = new_row2;
    end
    if (phase < 2) timeout("dut2_line");
    else begin
      cmp_int("dut2_line_len", len, 800);
      cmp_int("dut2_hsync_low", low, 96);
      cmp_int("dut2_ptick_gaps", pz, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
